// File: rtl/ht_pkg.sv
// Shared types and helpers for the sorting-datapath sequencer.
// Holds the FSM state encoding, the step-count type and the req_stages validation helper.
package ht_pkg;

    localparam int unsigned NSTAGE_DEF = 5;
    localparam int unsigned STAGE_W    = 3;

    typedef logic [STAGE_W-1:0] stage_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic   legal;
        stage_t k;
    } stage_cfg_t;

    // Out-of-range step counts run the full datapath and are flagged as illegal.
    function automatic stage_cfg_t stage_cfg(input stage_t req, input int unsigned nstage);
        stage_cfg_t cfg;
        cfg.legal = (req != '0) && (32'(req) <= nstage);
        cfg.k     = cfg.legal ? req : STAGE_W'(nstage);
        return cfg;
    endfunction

endpackage

// File: rtl/ht_lat_cnt.sv
// Loadable latency down-counter; last flags the final cycle of the count.
module ht_lat_cnt
    import ht_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // clr beats load beats decrement; the count never underflows below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/ht_seq.sv
// Job sequencer for the 32-lane sorting datapath: accepts jobs, pulses the input
// register load, times the selected number of steps and hands off the result.
module ht_seq
    import ht_pkg::*;
#(
    parameter int unsigned NSTAGE    = NSTAGE_DEF,
    parameter int unsigned STAGE_LAT = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [STAGE_W-1:0] req_stages,
    input  logic               flush,
    output logic               load_en,
    output logic [STAGE_W-1:0] stage_sel,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               over,
    output logic               busy,
    output logic               err_cfg,
    output logic [CNT_W-1:0]   jobs_done
);

    localparam int unsigned LAT_MAX = NSTAGE * STAGE_LAT;
    localparam int unsigned LCNT_W  = (LAT_MAX == 0) ? 1 : $clog2(LAT_MAX + 1);

    state_t             state_d;
    state_t             state_q;
    stage_t             stage_sel_d;
    stage_t             stage_sel_q;
    logic               err_cfg_d;
    logic               err_cfg_q;
    logic [CNT_W-1:0]   jobs_done_d;
    logic [CNT_W-1:0]   jobs_done_q;
    logic               over_d;
    logic               over_q;

    logic               acc_c;
    stage_cfg_t         cfg_c;
    logic [LCNT_W-1:0]  lat_c;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_last;

    // Handshake decode; flush blocks any new acceptance in its cycle.
    assign req_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & res_ready));
    assign acc_c     = req_valid & req_ready;
    assign load_en   = acc_c;
    assign cfg_c     = stage_cfg(req_stages, NSTAGE);
    assign lat_c     = LCNT_W'(32'(cfg_c.k) * STAGE_LAT);

    ht_lat_cnt #(
        .W (LCNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (lat_c),
        .last     (cnt_last)
    );

    // Next-state: flush aborts everything; an accept in DONE overrides the return to IDLE.
    always_comb begin
        state_d     = state_q;
        stage_sel_d = stage_sel_q;
        err_cfg_d   = err_cfg_q;
        jobs_done_d = jobs_done_q;
        over_d      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        jobs_done_d = jobs_done_q + CNT_W'(1);
                        over_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (acc_c) begin
                stage_sel_d = cfg_c.k;
                if (!cfg_c.legal) begin
                    err_cfg_d = 1'b1;
                end
                if (lat_c == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_sel_q <= STAGE_W'(NSTAGE);
            err_cfg_q   <= 1'b0;
            jobs_done_q <= '0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_sel_q <= stage_sel_d;
            err_cfg_q   <= err_cfg_d;
            jobs_done_q <= jobs_done_d;
            over_q      <= over_d;
        end
    end

    assign stage_sel = stage_sel_q;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign err_cfg   = err_cfg_q;
    assign jobs_done = jobs_done_q;
    assign over      = over_q;

endmodule

// File: tb/tb_ht_seq.sv
// Directed bench for ht_seq: per-cycle vector table on the default build (with a
// 2-bit-counter twin sharing its inputs) plus hand sequences for reset and STAGE_LAT=0.
module tb_ht_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        req_valid, req_ready, flush, load_en, res_valid, res_ready, over, busy, err_cfg;
    logic [2:0]  req_stages, stage_sel;
    logic [15:0] jobs_done;

    logic        w_req_ready, w_load_en, w_res_valid, w_over, w_busy, w_err_cfg;
    logic [2:0]  w_stage_sel;
    logic [1:0]  w_jobs_done;

    logic        z_req_valid, z_req_ready, z_flush, z_load_en, z_res_valid, z_res_ready;
    logic        z_over, z_busy, z_err_cfg;
    logic [2:0]  z_req_stages, z_stage_sel;
    logic [15:0] z_jobs_done;

    ht_seq dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_stages(req_stages), .flush(flush), .load_en(load_en), .stage_sel(stage_sel),
        .res_valid(res_valid), .res_ready(res_ready), .over(over), .busy(busy),
        .err_cfg(err_cfg), .jobs_done(jobs_done)
    );

    ht_seq #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready),
        .req_stages(req_stages), .flush(flush), .load_en(w_load_en), .stage_sel(w_stage_sel),
        .res_valid(w_res_valid), .res_ready(res_ready), .over(w_over), .busy(w_busy),
        .err_cfg(w_err_cfg), .jobs_done(w_jobs_done)
    );

    ht_seq #(.STAGE_LAT(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_stages(z_req_stages), .flush(z_flush), .load_en(z_load_en), .stage_sel(z_stage_sel),
        .res_valid(z_res_valid), .res_ready(z_res_ready), .over(z_over), .busy(z_busy),
        .err_cfg(z_err_cfg), .jobs_done(z_jobs_done)
    );

    typedef struct packed {
        logic        rv;
        logic [2:0]  rs;
        logic        fl;
        logic        rr;
        logic        e_rdy;
        logic        e_ld;
        logic [2:0]  e_sel;
        logic        e_vld;
        logic        e_over;
        logic        e_busy;
        logic        e_err;
        logic [15:0] e_jobs;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t v(input logic rv, input logic [2:0] rs, input logic fl, input logic rr,
                               input logic rdy, input logic ld, input logic [2:0] sel, input logic vld,
                               input logic ov, input logic bsy, input logic err, input logic [15:0] jobs);
        vec_t t;
        t = '{rv, rs, fl, rr, rdy, ld, sel, vld, ov, bsy, err, jobs};
        return t;
    endfunction

    function automatic logic [24:0] pack(input logic rdy, input logic ld, input logic [2:0] sel,
                                         input logic vld, input logic ov, input logic bsy,
                                         input logic err, input logic [15:0] jobs);
        return {rdy, ld, sel, vld, ov, bsy, err, jobs};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (rdy,ld,sel,vld,over,busy,err,jobs)", name, act, exp);
        end
    endtask

    // One cycle on the shared-input pair: drive, sample mid-cycle, advance to the next edge.
    task automatic run_vec(input vec_t t, input string name);
        logic [24:0] e;
        req_valid  = t.rv;
        req_stages = t.rs;
        flush      = t.fl;
        res_ready  = t.rr;
        e = pack(t.e_rdy, t.e_ld, t.e_sel, t.e_vld, t.e_over, t.e_busy, t.e_err, t.e_jobs);
        @(negedge clk);
        check(name, 64'({req_ready, load_en, stage_sel, res_valid, over, busy, err_cfg, jobs_done}),
              64'(e));
        check({name, "_w"},
              64'({w_req_ready, w_load_en, w_stage_sel, w_res_valid, w_over, w_busy, w_err_cfg, w_jobs_done}),
              64'({e[24:16], e[1:0]}));
        @(posedge clk);
        #1;
    endtask

    task automatic run_z(input logic rv, input logic [2:0] rs, input logic rr,
                         input logic [24:0] e, input string name);
        z_req_valid  = rv;
        z_req_stages = rs;
        z_res_ready  = rr;
        @(negedge clk);
        check(name, 64'({z_req_ready, z_load_en, z_stage_sel, z_res_valid, z_over, z_busy, z_err_cfg, z_jobs_done}),
              64'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_stages = 3'd0; flush = 1'b0; res_ready = 1'b0;
        z_req_valid = 1'b0; z_req_stages = 3'd0; z_flush = 1'b0; z_res_ready = 1'b0;

        // Reset state, then a full 5-step job with a delayed consumer.
        tbl.push_back(v(0,0,0,0, 1,0,5,0,0,0,0,0));
        tbl.push_back(v(1,5,0,0, 1,1,5,0,0,0,0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0, 0,0,5,0,0,1,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,5,1,0,1,0,0));
        tbl.push_back(v(0,0,0,0, 0,0,5,1,0,1,0,0));
        tbl.push_back(v(0,0,0,1, 1,0,5,1,0,1,0,0));
        tbl.push_back(v(0,0,0,0, 1,0,5,0,1,0,0,1));
        // Single step, back-to-back into a 2-step job; res_ready ignored while running.
        tbl.push_back(v(1,1,0,0, 1,1,5,0,0,0,0,1));
        tbl.push_back(v(0,0,0,0, 0,0,1,0,0,1,0,1));
        tbl.push_back(v(1,2,0,1, 1,1,1,1,0,1,0,1));
        tbl.push_back(v(0,0,0,1, 0,0,2,0,1,1,0,2));
        tbl.push_back(v(0,0,0,1, 0,0,2,0,0,1,0,2));
        tbl.push_back(v(0,0,0,0, 0,0,2,1,0,1,0,2));
        tbl.push_back(v(0,0,0,1, 1,0,2,1,0,1,0,2));
        tbl.push_back(v(0,0,0,0, 1,0,2,0,1,0,0,3));
        // Illegal step counts 0 and 7 both run five steps and set the sticky flag.
        tbl.push_back(v(1,0,0,0, 1,1,2,0,0,0,0,3));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0, 0,0,5,0,0,1,1,3));
        tbl.push_back(v(0,0,0,1, 1,0,5,1,0,1,1,3));
        tbl.push_back(v(0,0,0,0, 1,0,5,0,1,0,1,4));
        tbl.push_back(v(1,7,0,0, 1,1,5,0,0,0,1,4));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0, 0,0,5,0,0,1,1,4));
        tbl.push_back(v(0,0,0,1, 1,0,5,1,0,1,1,4));
        tbl.push_back(v(0,0,0,0, 1,0,5,0,1,0,1,5));
        // Flush in RUN at count 3, flush against a request in IDLE, flush against a handshake.
        tbl.push_back(v(1,4,0,0, 1,1,5,0,0,0,1,5));
        tbl.push_back(v(0,0,0,0, 0,0,4,0,0,1,1,5));
        tbl.push_back(v(1,3,1,1, 0,0,4,0,0,1,1,5));
        tbl.push_back(v(1,2,1,0, 0,0,4,0,0,0,1,5));
        tbl.push_back(v(0,0,0,0, 1,0,4,0,0,0,1,5));
        tbl.push_back(v(1,1,0,0, 1,1,4,0,0,0,1,5));
        tbl.push_back(v(0,0,0,0, 0,0,1,0,0,1,1,5));
        tbl.push_back(v(0,0,1,1, 0,0,1,1,0,1,1,5));
        tbl.push_back(v(0,0,0,0, 1,0,1,0,0,0,1,5));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while a result is waiting in DONE: everything returns to reset values.
        run_vec(v(1,3,0,0, 1,1,1,0,0,0,1,5), "rst_acc");
        run_vec(v(0,0,0,0, 0,0,3,0,0,1,1,5), "rst_run3");
        run_vec(v(0,0,0,0, 0,0,3,0,0,1,1,5), "rst_run2");
        run_vec(v(0,0,0,0, 0,0,3,0,0,1,1,5), "rst_run1");
        rst = 1'b1;
        run_vec(v(0,0,0,0, 0,0,3,1,0,1,1,5), "rst_done");
        rst = 1'b0;
        run_vec(v(0,0,0,0, 1,0,5,0,0,0,0,0), "rst_after");

        // Combinational steps: result valid the cycle after accept; back-to-back with an illegal count.
        run_z(1, 3'd3, 0, pack(1,1,5,0,0,0,0,16'd0), "z_acc");
        run_z(1, 3'd6, 1, pack(1,1,3,1,0,1,0,16'd0), "z_done_b2b");
        run_z(0, 3'd0, 1, pack(1,0,5,1,1,1,1,16'd1), "z_done2");
        run_z(0, 3'd0, 0, pack(1,0,5,0,1,0,1,16'd2), "z_over2");
        run_z(0, 3'd0, 0, pack(1,0,5,0,0,0,1,16'd2), "z_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ht_seq.md
Name: ht_seq

Overview:
- Sequencer for the 5-step, 32-lane sorting datapath (input capture register, then step1..step5).
- Owns the job handshake: accepts a job, pulses the datapath input-register load, and counts the datapath latency for the selected number of steps.
- Drives the output-mux select and presents a valid/ready result. Replaces the constant-zero "over" with a real completion pulse.
- Controller only; no data lanes pass through it.

Parameters:
- NSTAGE, 5, number of datapath steps (log2 of lane count).
- STAGE_LAT, 1, cycles from one step's input to its output; 0 means combinational steps.
- CNT_W, 16, width of the jobs_done counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  job request
- req_ready  out  1  sequencer can accept a job this cycle
- req_stages  in  3  steps to run, legal range 1..NSTAGE
- flush  in  1  synchronous abort of the current job
- load_en  out  1  datapath input-register capture enable
- stage_sel  out  3  output-mux select (1..NSTAGE), which step's output is the result
- res_valid  out  1  result on the datapath output is stable and valid
- res_ready  in  1  consumer accepts the result
- over  out  1  one-cycle pulse, the cycle after a result handshake
- busy  out  1  state != IDLE
- err_cfg  out  1  sticky flag, set when an illegal req_stages is accepted
- jobs_done  out  CNT_W  count of completed handshakes, wraps

Behaviour:
- Reset: state=IDLE, cnt=0, stage_sel=NSTAGE, err_cfg=0, jobs_done=0, over=0. Hence req_ready=1, res_valid=0, load_en=0, busy=0.
- States: IDLE, RUN, DONE.
- Accept condition: acc = req_valid & req_ready. load_en = acc (combinational, same cycle).
- req_ready = ~flush & (IDLE | (DONE & res_ready)).
- Stage count on acc:
  - k = req_stages when 1..NSTAGE.
  - Otherwise k = NSTAGE and err_cfg is set; err_cfg is cleared only by rst.
  - stage_sel <= k; it holds until the next acc.
- Latency count on acc: L = k*STAGE_LAT.
  - L==0: next state DONE.
  - Otherwise: next state RUN, cnt <= L.
- RUN: if cnt==1, go to DONE; else cnt decrements.
- Timing: for acc in cycle T, res_valid first asserts in cycle T+1+L.
- DONE:
  - res_valid=1. The datapath output stays stable because the input register changes only on load_en.
  - On res_valid & res_ready: jobs_done++, and over=1 in the next cycle.
  - After the handshake, go to IDLE, unless acc occurs in the same cycle (back-to-back); then load the new job as above.
- flush (any state): next state IDLE, cnt=0, no over pulse, jobs_done unchanged, no acc that cycle. flush wins over req_valid and res_ready.
- res_ready is ignored outside DONE.
- jobs_done wraps from 2^CNT_W-1 to 0.
- rst mid-job: immediate return to reset values; the in-flight result is discarded.
- cnt width is clog2(NSTAGE*STAGE_LAT+1), minimum 1.

Decomposition:
- Package ht_pkg:
  - state enum {IDLE, RUN, DONE}
  - NSTAGE_DEF=5
  - stage_t (3-bit) and a helper that clamps/validates req_stages
- Sub-module ht_lat_cnt: loadable down-counter with load/value inputs and a "last" (cnt==1) output. Instantiated once.

Test Plan:
- Basic timing (STAGE_LAT=1): req_stages=5 accepted in cycle 10 -> load_en=1 in cycle 10; res_valid rises in cycle 16; stage_sel=5. res_ready=1 in cycle 18 -> over=1 in cycle 19, jobs_done=1, busy=0 in cycle 19.
- Short job and combinational steps: req_stages=1 with STAGE_LAT=1 -> res_valid at T+2. req_stages=3 with STAGE_LAT=0 -> res_valid at T+1, stage_sel=3.
- Back-to-back: in DONE, res_ready=1 and req_valid=1 in the same cycle -> req_ready=1, load_en=1, over pulses next cycle, new job's res_valid at T+1+L. Two jobs complete, jobs_done=2.
- Illegal config: req_stages=0, then req_stages=7 -> both run as 5 steps (res_valid at T+6), err_cfg=1 and sticky; rst clears it to 0.
- flush priority: flush in RUN at cnt=3 -> IDLE next cycle, no over, jobs_done unchanged. flush=1 together with req_valid=1 in IDLE -> req_ready=0, load_en=0.
- Reset mid-job and wrap: rst in DONE -> res_valid=0, stage_sel=5, jobs_done=0. With CNT_W=2, four completed jobs -> jobs_done returns to 0.
